// File: rtl/cordic_output_stage_if.sv
// Handshake and data bundle between the CORDIC rotation pipeline, the output
// stage and its consumer.
`timescale 1ns/1ps
interface cordic_output_stage_if;
  logic               start;
  logic               flip;
  logic               start_ready;
  logic signed [31:0] x_in;
  logic signed [31:0] y_in;
  logic signed [31:0] z_in;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;
  logic signed [31:0] z_res;
  logic               out_valid;
  logic               out_ready;
  logic               overflow;

  modport slave (
    input  start, flip, x_in, y_in, z_in, out_ready,
    output start_ready, cos_out, sin_out, z_res, out_valid, overflow
  );

  modport master (
    output start, flip, x_in, y_in, z_in, out_ready,
    input  start_ready, cos_out, sin_out, z_res, out_valid, overflow
  );
endinterface

// File: rtl/cordic_output_stage.sv
// CORDIC output stage: tracks issued angles through the rotation pipeline,
// undoes the pi fold on arrival and buffers results in a credit-managed FIFO.
`timescale 1ns/1ps
module cordic_output_stage #(
  parameter int PIPE_DEPTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  cordic_output_stage_if.slave io
);
  localparam int             AW      = $clog2(FIFO_DEPTH);
  localparam int             CW      = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0]  CNT_MAX = CW'(FIFO_DEPTH);
  localparam logic [AW:0]    PTR_MSB = {1'b1, {AW{1'b0}}};

  // Negating the most negative value would wrap back onto itself.
  function automatic logic signed [31:0] sat_neg(input logic signed [31:0] v);
    if (v == 32'sh8000_0000) return 32'sh7FFF_FFFF;
    return -v;
  endfunction

  logic [PIPE_DEPTH-1:0] vld_q, vld_d;
  logic [PIPE_DEPTH-1:0] flp_q, flp_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  ovf_q, ovf_d;

  logic                  tail_vld, tail_flp;
  logic                  issue, push, pop, wr_en, full, empty;
  logic signed [31:0]    x_cor, y_cor;

  logic signed [31:0]    cos_mem [FIFO_DEPTH];
  logic signed [31:0]    sin_mem [FIFO_DEPTH];
  logic signed [31:0]    z_mem   [FIFO_DEPTH];

  assign tail_vld = vld_q[PIPE_DEPTH-1];
  assign tail_flp = flp_q[PIPE_DEPTH-1];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == PTR_MSB);

  assign io.start_ready = (count_q < CNT_MAX);
  assign issue          = io.start & io.start_ready;
  assign pop            = ~empty & io.out_ready;
  assign push           = tail_vld;
  // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
  assign wr_en          = push & (~full | pop);

  assign x_cor = tail_flp ? sat_neg(io.x_in) : io.x_in;
  assign y_cor = tail_flp ? sat_neg(io.y_in) : io.y_in;

  always_comb begin
    vld_d    = (vld_q << 1) | PIPE_DEPTH'(issue);
    flp_d    = (flp_q << 1) | PIPE_DEPTH'(io.flip);
    wr_ptr_d = wr_ptr_q + (AW+1)'(wr_en);
    rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    ovf_d    = ovf_q | (push & full & ~pop);
    count_d  = count_q;
    case ({issue, pop && (count_q != '0)})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= '0;
      flp_q    <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      vld_q    <= vld_d;
      flp_q    <= flp_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      cos_mem[wr_ptr_q[AW-1:0]] <= x_cor;
      sin_mem[wr_ptr_q[AW-1:0]] <= y_cor;
      z_mem[wr_ptr_q[AW-1:0]]   <= io.z_in;
    end
  end

  assign io.out_valid = ~empty;
  assign io.overflow  = ovf_q;
  assign io.cos_out   = empty ? '0 : cos_mem[rd_ptr_q[AW-1:0]];
  assign io.sin_out   = empty ? '0 : sin_mem[rd_ptr_q[AW-1:0]];
  assign io.z_res     = empty ? '0 : z_mem[rd_ptr_q[AW-1:0]];
endmodule

// File: doc/cordic_output_stage.md
CORDIC_OUTPUT_STAGE -- requirements
Module: cordic_output_stage

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 16: clock cycles from start accepted to final rotation-stage result present on x_in/y_in/z_in.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, power of two, 2..16: number of result entries buffered.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port start, input, 1 bit: upstream issues an angle into rotation stage 0 this cycle.
REQ-006 SHALL have port flip, input, 1 bit: angle was folded by pi at issue; sampled with start.
REQ-007 SHALL have port start_ready, output, 1 bit: a start this cycle is guaranteed a FIFO slot.
REQ-008 SHALL have ports x_in, y_in, z_in, input, 32 bits each, signed: outputs of the final rotation stage.
REQ-009 SHALL have ports cos_out, sin_out, z_res, output, 32 bits each, signed: FIFO head.
REQ-010 SHALL have port out_valid, output, 1 bit: FIFO head valid.
REQ-011 SHALL have port out_ready, input, 1 bit: consumer accepts head.
REQ-012 SHALL have port overflow, output, 1 bit: sticky, a result was dropped.

Function
REQ-013 SHALL track issues with a PIPE_DEPTH-bit valid delay line and a PIPE_DEPTH-bit flip delay line, both shifted every cycle; bit 0 loads start&start_ready and flip.
REQ-014 SHALL treat start while start_ready=0 as not issued: delay-line bit 0 loads 0, credit unchanged.
REQ-015 SHALL capture x_in/y_in/z_in in the cycle the delay-line tail valid bit is 1, exactly PIPE_DEPTH cycles after issue.
REQ-016 SHALL, when the tail flip bit is 1, write -x_in and -y_in; otherwise x_in and y_in unchanged. z_in SHALL never be negated.
REQ-017 SHALL saturate negation: -32'h80000000 yields 32'h7FFFFFFF; all other values use exact two's complement.
REQ-018 SHALL push the corrected triple into the FIFO on the capture cycle; data is visible on outputs the next cycle when the FIFO was empty.
REQ-019 SHALL keep a credit count = results in flight + FIFO occupancy, range 0..FIFO_DEPTH; start_ready = (count < FIFO_DEPTH), combinational from registered count.
REQ-020 SHALL increment count on issue and decrement on pop (out_valid&out_ready); both in one cycle leaves count unchanged.
REQ-021 SHALL pop the FIFO head when out_valid&out_ready; head data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-022 SHALL accept push and pop in the same cycle, including when full, where pop frees the slot for the push.
REQ-023 SHALL assert out_valid whenever FIFO occupancy > 0; outputs SHALL be 0 when empty.
REQ-024 SHALL, if a push arrives with FIFO full and no pop (only reachable when PIPE_DEPTH is mismatched to the pipeline), drop the push, keep FIFO contents, and set overflow until reset.
REQ-025 SHALL wrap read/write pointers modulo FIFO_DEPTH using a 1-bit-wider pointer for full/empty discrimination.

Reset
REQ-026 SHALL, on rst_n low, asynchronously clear both delay lines, credit count, FIFO pointers and overflow; cos_out, sin_out, z_res, out_valid = 0; start_ready = 1 once rst_n is sampled high.
REQ-027 SHALL discard results in flight at reset; a result matching a pre-reset issue SHALL NOT be pushed after reset.
REQ-028 SHALL ignore start, x_in, y_in, z_in and out_ready while rst_n is low.

Verification
REQ-029 Single issue, flip=0, x_in=32'h26DD3B6A, y_in=32'h12345678, z_in=32'h00000003 at cycle issue+16 -> out_valid at issue+17, cos_out=32'h26DD3B6A, sin_out=32'h12345678, z_res=3.
REQ-030 Single issue, flip=1, x_in=32'h00001000, y_in=32'h80000000 -> cos_out=32'hFFFFF000, sin_out=32'h7FFFFFFF, z_res unchanged.
REQ-031 out_ready=0, start held every cycle -> exactly 4 issues accepted, start_ready=0 after the 4th; one pop -> start_ready=1 next cycle, 5th issue accepted.
REQ-032 Full FIFO, push and pop in same cycle -> occupancy stays 4, order preserved, overflow=0.
REQ-033 Bench forces tail valid with FIFO full and out_ready=0 -> push dropped, FIFO unchanged, overflow=1 until rst_n low.
REQ-034 Issue at cycle 0, rst_n low cycle 5 to 6 -> out_valid stays 0 through cycle 30, count=0, start_ready=1.
